eco32f_wb_arbiter: RTL

Two-master Wishbone B3 arbiter that shares the single external bus between the instruction-fetch port (icache refill) and the load/store unit data port. Sits between the core's two bus masters and the SoC interconnect. It grants one master at a time, holds the grant for the whole cycle including incrementing bursts, and enforces a bus watchdog. A slave that never terminates a cycle produces a synthesized error instead of hanging the pipeline.

---
 rtl/eco32f_wb_arbiter_pkg.sv | 20 ++
 rtl/eco32f_wb_watchdog.sv | 35 +++
 rtl/eco32f_wb_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/eco32f_wb_arbiter_pkg.sv
// Shared constants for the eco32f Wishbone bus masters.
//   arb_state_t : arbiter state encoding (also exported on the arbiter debug port)
//   CTI_* / BTE_*: Wishbone B3 cycle-type and burst-type codes used by the
//                  icache, the LSU and the arbiter.
package eco32f_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10,
        ARB_ABORT = 2'b11
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_WRAP8   = 2'b10;

endpackage

// File: rtl/eco32f_wb_watchdog.sv
// Bus watchdog counter.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : a granted strobe is waiting this cycle (no termination)
//   clear      : restart the count (idle bus, termination, or abort)
//   expire     : combinational; high when this is the TIMEOUT-th waiting cycle
module eco32f_wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    // TIMEOUT-1 is the largest value the counter ever holds, so
    // clog2(TIMEOUT) bits are always enough (TIMEOUT >= 2).
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign expire = enable && (wd_cnt == LIMIT);

endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Two-master Wishbone B3 arbiter: instruction port (iwbm_*) and data port
// (dwbm_*) share one external bus (wbm_*).
//   iwbm_*_i / iwbm_*_o : instruction master request / termination + read data
//   dwbm_*_i / dwbm_*_o : data master request + write data / termination + read data
//   wbm_*_o  / wbm_*_i  : shared bus request / response
//   arb_timeout_o       : one-cycle pulse when the watchdog aborts a cycle
//   dbg_state           : current arbiter state
//
// Handshake: a master owns the bus from the cycle after it is granted until
// the cycle it drops cyc; the grant is never taken away mid-burst except by
// the watchdog. Terminations (ack/err/rty) pass combinationally from the bus
// to the granted master only; the bus request side is driven only from state
// and master inputs, never from bus responses.
module eco32f_wb_arbiter
    import eco32f_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] iwbm_adr_i,
    input  logic [3:0]  iwbm_sel_i,
    input  logic [2:0]  iwbm_cti_i,
    input  logic [1:0]  iwbm_bte_i,
    input  logic        iwbm_cyc_i,
    input  logic        iwbm_stb_i,
    input  logic        iwbm_we_i,
    output logic        iwbm_ack_o,
    output logic        iwbm_err_o,
    output logic        iwbm_rty_o,
    output logic [31:0] iwbm_dat_o,

    input  logic [31:0] dwbm_adr_i,
    input  logic [3:0]  dwbm_sel_i,
    input  logic [2:0]  dwbm_cti_i,
    input  logic [1:0]  dwbm_bte_i,
    input  logic        dwbm_cyc_i,
    input  logic        dwbm_stb_i,
    input  logic        dwbm_we_i,
    input  logic [31:0] dwbm_dat_i,
    output logic        dwbm_ack_o,
    output logic        dwbm_err_o,
    output logic        dwbm_rty_o,
    output logic [31:0] dwbm_dat_o,

    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i,

    output logic        arb_timeout_o,
    output arb_state_t  dbg_state
);

    arb_state_t state, state_nxt;
    logic       last_gnt_d, last_gnt_d_nxt;   // 1: data master granted last
    logic       gnt_i, gnt_d, bus_term;
    logic       wd_enable, wd_clear, wd_expire;

    assign gnt_i    = (state == ARB_GNT_I);
    assign gnt_d    = (state == ARB_GNT_D);
    assign bus_term = wbm_ack_i || wbm_err_i || wbm_rty_i;

    // Only a live strobe of the owner waits; a termination in the same cycle
    // as the limit wins over the abort.
    assign wd_enable = ((gnt_i && iwbm_cyc_i && iwbm_stb_i) ||
                        (gnt_d && dwbm_cyc_i && dwbm_stb_i)) && !bus_term;
    assign wd_clear  = (state == ARB_IDLE) || bus_term || wd_expire;

    eco32f_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (wd_enable),
        .clear  (wd_clear),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_gnt_d <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_gnt_d <= last_gnt_d_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_gnt_d_nxt = last_gnt_d;
        case (state)
            ARB_IDLE: begin
                // On a tie the master that was not granted last wins.
                if (dwbm_cyc_i && (!iwbm_cyc_i || !last_gnt_d)) begin
                    state_nxt      = ARB_GNT_D;
                    last_gnt_d_nxt = 1'b1;
                end else if (iwbm_cyc_i) begin
                    state_nxt      = ARB_GNT_I;
                    last_gnt_d_nxt = 1'b0;
                end
            end
            ARB_GNT_I: begin
                if (!iwbm_cyc_i)    state_nxt = ARB_IDLE;
                else if (wd_expire) state_nxt = ARB_ABORT;
            end
            ARB_GNT_D: begin
                if (!dwbm_cyc_i)    state_nxt = ARB_IDLE;
                else if (wd_expire) state_nxt = ARB_ABORT;
            end
            ARB_ABORT: begin
                // last_gnt_d still names the master whose cycle was aborted.
                if (last_gnt_d ? !dwbm_cyc_i : !iwbm_cyc_i) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        wbm_adr_o = dwbm_adr_i;
        wbm_sel_o = dwbm_sel_i;
        wbm_cti_o = dwbm_cti_i;
        wbm_bte_o = dwbm_bte_i;
        wbm_dat_o = dwbm_dat_i;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        if (gnt_i) begin
            wbm_adr_o = iwbm_adr_i;
            wbm_sel_o = iwbm_sel_i;
            wbm_cti_o = iwbm_cti_i;
            wbm_bte_o = iwbm_bte_i;
            wbm_cyc_o = iwbm_cyc_i;
            wbm_stb_o = iwbm_stb_i;
            wbm_we_o  = iwbm_we_i;
        end else if (gnt_d) begin
            wbm_cyc_o = dwbm_cyc_i;
            wbm_stb_o = dwbm_stb_i;
            wbm_we_o  = dwbm_we_i;
        end
    end

    // wd_expire can only be high while a master is granted.
    assign iwbm_ack_o    = gnt_i && wbm_ack_i;
    assign iwbm_err_o    = gnt_i && (wbm_err_i || wd_expire);
    assign iwbm_rty_o    = gnt_i && wbm_rty_i;
    assign dwbm_ack_o    = gnt_d && wbm_ack_i;
    assign dwbm_err_o    = gnt_d && (wbm_err_i || wd_expire);
    assign dwbm_rty_o    = gnt_d && wbm_rty_i;

    assign iwbm_dat_o    = wbm_dat_i;
    assign dwbm_dat_o    = wbm_dat_i;
    assign arb_timeout_o = wd_expire;
    assign dbg_state     = state;

endmodule
